// File: rtl/bitwise_logic_pkg.sv
// Opcode encoding shared by the bitwise logic unit and anything that drives it.
package bitwise_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/lu_skid_buf.sv
// Two-entry output buffer (main + skid) with a registered in_ready, so the
// upstream handshake never depends combinationally on out_ready.
module lu_skid_buf #(
  parameter int PAYLOAD_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] main_p1;
  logic                 skid_vld_p1;
  logic [PAYLOAD_W-1:0] skid_p1;

  logic accept;
  logic take;

  assign accept      = in_valid && !skid_vld_p1;
  assign take        = vld_p1 && out_ready;
  assign in_ready    = !skid_vld_p1;
  assign out_valid   = vld_p1;
  assign out_payload = main_p1;

  // Stage p1: main holds the head of the FIFO, skid catches an accept that
  // arrives while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
    end else if (take) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_p1 <= in_payload;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (vld_p1) begin
        skid_p1     <= in_payload;
        skid_vld_p1 <= 1'b1;
      end else begin
        main_p1 <= in_payload;
        vld_p1  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise ALU: eight selectable operations, registered result with
// zero/all-ones flags, skid-buffered handshake and a saturating transfer count.
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] op_count
);

  function automatic logic [WIDTH-1:0] apply_op(input logic [OP_W-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      OP_PASSA: r = a;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] res_p0;
  logic             zero_p0;
  logic             ones_p0;
  logic [WIDTH+1:0] payload_p1;
  logic [CNT_W-1:0] count_p1;

  // Stage p0: combinational decode and flag generation on the incoming operands.
  always_comb begin
    res_p0  = apply_op(in_op, in_a, in_b);
    zero_p0 = ~|res_p0;
    ones_p0 = &res_p0;
  end

  lu_skid_buf #(
    .PAYLOAD_W(WIDTH + 2)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload ({zero_p0, ones_p0, res_p0}),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(payload_p1)
  );

  assign out_zero = payload_p1[WIDTH+1];
  assign out_ones = payload_p1[WIDTH];
  assign out_data = payload_p1[WIDTH-1:0];

  // Stage p1: count completed output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1 <= '0;
    end else if (out_valid && out_ready) begin
      count_p1 <= sat_inc(count_p1);
    end
  end

  assign op_count = count_p1;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: a driver queues expected results on
// each accepted input, a monitor pops and compares on each output transfer.
module tb_bitwise_logic_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] op_count;

  bitwise_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero),
    .out_ones (out_ones),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [CNT_W-1:0] cnt_model = '0;
  bit               stall_prev = 1'b0;
  logic [WIDTH+1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (op == 3'd0)      r[i] = a[i] && b[i];
      else if (op == 3'd1) r[i] = a[i] || b[i];
      else if (op == 3'd2) r[i] = !(a[i] && b[i]);
      else if (op == 3'd3) r[i] = !(a[i] || b[i]);
      else if (op == 3'd4) r[i] = a[i] != b[i];
      else if (op == 3'd5) r[i] = a[i] == b[i];
      else if (op == 3'd6) r[i] = !a[i];
      else                 r[i] = a[i];
    end
    return r;
  endfunction

  // Monitor: every negedge; an out_valid && out_ready seen here transfers at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    chk("op_count", 32'(op_count), 32'(cnt_model));
    if (rst) begin
      sb.delete();
      cnt_model  = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_payload", 32'({out_zero, out_ones, out_data}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_zero", 32'(out_zero), 32'(e.zero));
          chk("out_ones", 32'(out_ones), 32'(e.ones));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd1);
        end
        if (cnt_model != '1) cnt_model = cnt_model + 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_zero, out_ones, out_data};
    end
  end

  // Offer one transfer; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expd,
                      input bit lat);
    exp_t e;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.data = expd;
        e.zero = (expd == '0);
        e.ones = (expd == '1);
        e.acc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        break;
      end
      if (t >= 200) begin
        chk("accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
      if (t >= 300) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit done;
    logic [2:0]       rop;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] t1 [8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_zero, out_ones}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: all eight ops back-to-back on F0/3C.
    t1 = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'h3C, t1[i], 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Test 2: flag corner cases.
    send(3'd2, 8'hFF, 8'hFF, 8'h00, 1'b1);
    send(3'd3, 8'h00, 8'h00, 8'hFF, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Test 3: backpressure fills main and skid, third op is held off.
    out_ready = 1'b0;
    send(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    send(3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    in_op = 3'd4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h30);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Test 4: counter saturation.
    pulse_reset();
    for (int i = 0; i < 20; i++) send(3'd7, 8'(i), 8'h00, 8'(i), 1'b1);
    in_valid = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("count_saturated", 32'(op_count), 32'd15);
    @(posedge clk);
    #1;

    // Test 5: reset with both entries full; inputs during reset are ignored.
    out_ready = 1'b0;
    send(3'd7, 8'hA1, 8'h00, 8'hA1, 1'b0);
    send(3'd7, 8'hA2, 8'h00, 8'hA2, 1'b0);
    rst = 1'b1;
    in_op = 3'd7; in_a = 8'h55; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_op_count", 32'(op_count), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_data", 32'(out_data), 32'd0);
    chk("flush_flags", 32'({out_zero, out_ones}), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Test 6: random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          rop = 3'($urandom_range(0, 7));
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          send(rop, ra, rb, ref_op(rop, ra, rb), 1'b0);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
